// File: rtl/ex_acc_pkg.sv
// Shared definitions for the accumulator execute stage.
//   - ALU function codes (funct field)
//   - forward-select codes (fwd field)
//   - bit positions inside the pass-through control bus
//   - execute-stage FSM state type
package ex_acc_pkg;

    localparam logic [2:0] FUNCT_ADD  = 3'b000;
    localparam logic [2:0] FUNCT_SUB  = 3'b001;
    localparam logic [2:0] FUNCT_AND  = 3'b010;
    localparam logic [2:0] FUNCT_OR   = 3'b011;
    localparam logic [2:0] FUNCT_XOR  = 3'b100;
    localparam logic [2:0] FUNCT_SLT  = 3'b101;
    localparam logic [2:0] FUNCT_MUL  = 3'b110;
    localparam logic [2:0] FUNCT_PASS = 3'b111;

    localparam logic [1:0] FWD_BASE = 2'b00;
    localparam logic [1:0] FWD_ACC  = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] FWD_ALT  = 2'b11;  // behaves as FWD_BASE

    localparam int unsigned CTRL_WR  = 0;
    localparam int unsigned CTRL_WM  = 1;
    localparam int unsigned CTRL_RM  = 2;
    localparam int unsigned CTRL_NEQ = 3;
    localparam int unsigned CTRL_J   = 4;
    localparam int unsigned CTRL_JC  = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } exState_t;

endpackage

// File: rtl/ex_acc_mul.sv
// Iterative shift-add multiplier (low WIDTH bits of the product).
//   clock, reset   : stage clock, synchronous active-high reset (aborts a run)
//   start          : latch operands, clear product, begin WIDTH iterations
//   multiplicand   : operand A
//   multiplier     : operand acc_in
//   done           : high during the final iteration cycle
//   product        : product including the current iteration; valid when done
module ex_acc_mul #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    import ex_acc_pkg::*;

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             busy;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] prod;
    logic [WIDTH-1:0] stepProd;

    // Product after this cycle's add; exposed so the stage can write the
    // result on the same edge as the last iteration.
    always_comb begin
        stepProd = prod + (mplier[0] ? mcand : '0);
    end

    assign product = stepProd;
    assign done    = busy && (count == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            busy   <= 1'b0;
            count  <= '0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            count  <= CW'(WIDTH - 1);
            mcand  <= multiplicand;
            mplier <= multiplier;
            prod   <= '0;
        end else if (busy) begin
            prod   <= stepProd;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - 1'b1;
            if (count == '0) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_acc_stage.sv
// Execute stage of the accumulator pipeline (decode -> EX -> memory).
//   clock, reset          : stage clock, synchronous active-high reset
//   in_valid / in_ready   : decode handshake; accept = in_valid && in_ready
//   funct, acc_ld, imm_sel, set_out : operation controls
//   pc, reg_val, sinal_ext, data_mem, fwd : operands and forwarding
//   rd_in, ctrl_in        : pass-through destination and control bits
//   out_valid             : memory-stage outputs carry a real instruction
//   acc_out, zero_out     : accumulator output register and zero flag
//   jump_target, rs_out, rd_out, ctrl_out : registered pipeline outputs
module ex_acc_stage #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned RD_W   = 2,
    parameter int unsigned CTRL_W = 6,
    parameter int unsigned MUL_EN = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        funct,
    input  logic              acc_ld,
    input  logic              imm_sel,
    input  logic              set_out,
    input  logic [WIDTH-1:0]  pc,
    input  logic [WIDTH-1:0]  reg_val,
    input  logic [WIDTH-1:0]  sinal_ext,
    input  logic [1:0]        fwd,
    input  logic [WIDTH-1:0]  data_mem,
    input  logic [RD_W-1:0]   rd_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    output logic              out_valid,
    output logic [WIDTH-1:0]  acc_out,
    output logic              zero_out,
    output logic [WIDTH-1:0]  jump_target,
    output logic [WIDTH-1:0]  rs_out,
    output logic [RD_W-1:0]   rd_out,
    output logic [CTRL_W-1:0] ctrl_out
);
    import ex_acc_pkg::*;

    exState_t state, nextState;

    logic [WIDTH-1:0]  accIn;
    logic [WIDTH-1:0]  aVal;
    logic [WIDTH-1:0]  ldVal;
    logic [WIDTH-1:0]  ldBase;
    logic [WIDTH-1:0]  aluRes;
    logic              accept;
    logic              isMul;
    logic              mulStart;
    logic              mulDone;
    logic [WIDTH-1:0]  mulProd;

    // Fields of an in-flight multiply, written to the outputs when it ends.
    logic              pendSet;
    logic [WIDTH-1:0]  pendJmp;
    logic [WIDTH-1:0]  pendRs;
    logic [RD_W-1:0]   pendRd;
    logic [CTRL_W-1:0] pendCtrl;

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign isMul    = (MUL_EN != 0) && (funct == FUNCT_MUL) && !acc_ld;
    assign mulStart = accept && isMul;

    // Forwarding muxes: acc_out read here is the pre-edge value.
    always_comb begin
        ldBase = imm_sel ? sinal_ext : reg_val;
        case (fwd)
            FWD_ACC: begin
                aVal  = acc_out;
                ldVal = acc_out;
            end
            FWD_MEM: begin
                aVal  = data_mem;
                ldVal = data_mem;
            end
            default: begin
                aVal  = reg_val;
                ldVal = ldBase;
            end
        endcase
    end

    always_comb begin
        aluRes = aVal;
        case (funct)
            FUNCT_ADD:  aluRes = aVal + accIn;
            FUNCT_SUB:  aluRes = aVal - accIn;
            FUNCT_AND:  aluRes = aVal & accIn;
            FUNCT_OR:   aluRes = aVal | accIn;
            FUNCT_XOR:  aluRes = aVal ^ accIn;
            FUNCT_SLT:  aluRes = {{(WIDTH-1){1'b0}}, ($signed(aVal) < $signed(accIn))};
            default:    aluRes = aVal;  // PASS, and MUL when the multiplier is absent
        endcase
    end

    ex_acc_mul #(
        .WIDTH(WIDTH)
    ) uMul (
        .clock       (clock),
        .reset       (reset),
        .start       (mulStart),
        .multiplicand(aVal),
        .multiplier  (accIn),
        .done        (mulDone),
        .product     (mulProd)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: if (mulStart) nextState = ST_MUL;
            ST_MUL:  if (mulDone)  nextState = ST_IDLE;
            default: nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            accIn       <= '0;
            acc_out     <= '0;
            zero_out    <= 1'b0;
            jump_target <= '0;
            rs_out      <= '0;
            rd_out      <= '0;
            ctrl_out    <= '0;
            out_valid   <= 1'b0;
            pendSet     <= 1'b0;
            pendJmp     <= '0;
            pendRs      <= '0;
            pendRd      <= '0;
            pendCtrl    <= '0;
        end else begin
            // Bubble unless an instruction completes on this edge.
            out_valid <= 1'b0;
            ctrl_out  <= '0;
            if (accept) begin
                if (isMul) begin
                    pendSet  <= set_out;
                    pendJmp  <= pc + sinal_ext;
                    pendRs   <= aVal;
                    pendRd   <= rd_in;
                    pendCtrl <= ctrl_in;
                end else begin
                    if (acc_ld) begin
                        accIn <= ldVal;
                    end else if (set_out) begin
                        acc_out  <= aluRes;
                        zero_out <= (aluRes == '0);
                    end
                    jump_target <= pc + sinal_ext;
                    rs_out      <= aVal;
                    rd_out      <= rd_in;
                    ctrl_out    <= ctrl_in;
                    out_valid   <= 1'b1;
                end
            end else if (state == ST_MUL && mulDone) begin
                if (pendSet) begin
                    acc_out  <= mulProd;
                    zero_out <= (mulProd == '0);
                end
                jump_target <= pendJmp;
                rs_out      <= pendRs;
                rd_out      <= pendRd;
                ctrl_out    <= pendCtrl;
                out_valid   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ex_acc_stage.sv
module tb_ex_acc_stage;

    localparam int unsigned W = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    funct;
    logic          acc_ld;
    logic          imm_sel;
    logic          set_out;
    logic [W-1:0]  pc;
    logic [W-1:0]  reg_val;
    logic [W-1:0]  sinal_ext;
    logic [1:0]    fwd;
    logic [W-1:0]  data_mem;
    logic [1:0]    rd_in;
    logic [5:0]    ctrl_in;
    logic          out_valid;
    logic [W-1:0]  acc_out;
    logic          zero_out;
    logic [W-1:0]  jump_target;
    logic [W-1:0]  rs_out;
    logic [1:0]    rd_out;
    logic [5:0]    ctrl_out;

    int nChecks = 0;
    int nErrors = 0;

    // Reference state
    logic [W-1:0] mAccIn;
    logic [W-1:0] mAccOut;
    logic         mZero;

    ex_acc_stage #(
        .WIDTH (W),
        .RD_W  (2),
        .CTRL_W(6),
        .MUL_EN(1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .funct      (funct),
        .acc_ld     (acc_ld),
        .imm_sel    (imm_sel),
        .set_out    (set_out),
        .pc         (pc),
        .reg_val    (reg_val),
        .sinal_ext  (sinal_ext),
        .fwd        (fwd),
        .data_mem   (data_mem),
        .rd_in      (rd_in),
        .ctrl_in    (ctrl_in),
        .out_valid  (out_valid),
        .acc_out    (acc_out),
        .zero_out   (zero_out),
        .jump_target(jump_target),
        .rs_out     (rs_out),
        .rd_out     (rd_out),
        .ctrl_out   (ctrl_out)
    );

    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] refAlu(input logic [2:0] f, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        int sa, sb;
        logic [2*W-1:0] p;
        sa = int'($signed(a));
        sb = int'($signed(b));
        p  = a * b;
        case (f)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return (sa < sb) ? W'(1) : W'(0);
            3'd6:    return p[W-1:0];
            default: return a;
        endcase
    endfunction

    task automatic idleInputs();
        in_valid  = 1'b0;
        funct     = 3'd0;
        acc_ld    = 1'b0;
        imm_sel   = 1'b0;
        set_out   = 1'b0;
        pc        = '0;
        reg_val   = '0;
        sinal_ext = '0;
        fwd       = 2'b00;
        data_mem  = '0;
        rd_in     = '0;
        ctrl_in   = '0;
    endtask

    task automatic modelReset();
        mAccIn  = '0;
        mAccOut = '0;
        mZero   = 1'b0;
    endtask

    // Issue one instruction, wait for it to reach the outputs, and compare
    // every registered output against the reference.
    task automatic doOp(input logic [2:0] f, input logic ld, input logic isel, input logic so,
                        input logic [W-1:0] p, input logic [W-1:0] rv, input logic [W-1:0] se,
                        input logic [1:0] fw, input logic [W-1:0] dm, input logic [1:0] rd,
                        input logic [5:0] ct);
        logic [W-1:0] aExp, ldExp, res;
        logic         mul;
        int           lat;
        @(negedge clock);
        in_valid = 1'b1; funct = f; acc_ld = ld; imm_sel = isel; set_out = so;
        pc = p; reg_val = rv; sinal_ext = se; fwd = fw; data_mem = dm;
        rd_in = rd; ctrl_in = ct;
        checkVal("ready_before", {31'b0, in_ready}, 32'd1);

        aExp  = (fw == 2'b01) ? mAccOut : (fw == 2'b10) ? dm : rv;
        ldExp = (fw == 2'b01) ? mAccOut : (fw == 2'b10) ? dm : (isel ? se : rv);
        mul   = (f == 3'd6) && !ld;
        res   = refAlu(f, aExp, mAccIn);

        @(posedge clock); #1;
        if (mul) begin
            lat = 0;
            while (out_valid !== 1'b1 && lat < 40) begin
                checkVal("mul_stall_ready", {31'b0, in_ready}, 32'd0);
                @(negedge clock);
                // Garbage offered during the stall must be ignored.
                in_valid = 1'b1; funct = 3'($urandom_range(0, 7));
                acc_ld = 1'($urandom_range(0, 1)); set_out = 1'b1;
                reg_val = W'($urandom); data_mem = W'($urandom); ctrl_in = 6'($urandom);
                @(posedge clock); #1;
                lat++;
            end
            checkVal("mul_latency", lat, W);
        end

        if (ld) begin
            mAccIn = ldExp;
        end else if (so) begin
            mAccOut = res;
            mZero   = (res == '0);
        end

        checkVal("out_valid", {31'b0, out_valid}, 32'd1);
        checkVal("acc_out", {16'b0, acc_out}, {16'b0, mAccOut});
        checkVal("zero_out", {31'b0, zero_out}, {31'b0, mZero});
        checkVal("jump_target", {16'b0, jump_target}, {16'b0, W'(p + se)});
        checkVal("rd_out", {30'b0, rd_out}, {30'b0, rd});
        checkVal("ctrl_out", {26'b0, ctrl_out}, {26'b0, ct});
        if (!ld) checkVal("rs_out", {16'b0, rs_out}, {16'b0, aExp});
        if (mul) checkVal("ready_after_mul", {31'b0, in_ready}, 32'd1);

        @(negedge clock);
        idleInputs();
    endtask

    initial begin
        logic sawValid;
        idleInputs();
        modelReset();

        // Reset held two cycles
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checkVal("rst_acc_out", {16'b0, acc_out}, 32'd0);
        checkVal("rst_zero", {31'b0, zero_out}, 32'd0);
        checkVal("rst_valid", {31'b0, out_valid}, 32'd0);
        checkVal("rst_ready", {31'b0, in_ready}, 32'd1);
        checkVal("rst_jump", {16'b0, jump_target}, 32'd0);
        checkVal("rst_rs", {16'b0, rs_out}, 32'd0);
        checkVal("rst_rd", {30'b0, rd_out}, 32'd0);
        checkVal("rst_ctrl", {26'b0, ctrl_out}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Load then add, then subtract to zero
        doOp(3'd0, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0005, 2'b00, 16'h0, 2'd1, 6'h01);
        doOp(3'd0, 1'b0, 1'b0, 1'b1, 16'h0012, 16'h000A, 16'h0000, 2'b00, 16'h0, 2'd2, 6'h3F);
        checkVal("add_const", {16'b0, acc_out}, 32'h000F);
        doOp(3'd1, 1'b0, 1'b0, 1'b1, 16'h0014, 16'h0005, 16'h0000, 2'b00, 16'h0, 2'd3, 6'h02);
        checkVal("sub_zero_flag", {31'b0, zero_out}, 32'd1);

        // Forwarding
        doOp(3'd7, 1'b0, 1'b0, 1'b1, 16'h0, 16'h1234, 16'h0, 2'b00, 16'h0, 2'd0, 6'h04);
        doOp(3'd7, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0000, 16'h0, 2'b01, 16'h0, 2'd0, 6'h08);
        checkVal("fwd_acc_rs", {16'b0, rs_out}, 32'h1234);
        doOp(3'd0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0000, 16'h7777, 2'b10, 16'hBEEF, 2'd0, 6'h10);
        doOp(3'd4, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0000, 16'h0, 2'b00, 16'h0, 2'd0, 6'h20);
        checkVal("fwd_mem_ld", {16'b0, acc_out}, 32'hBEEF);
        doOp(3'd7, 1'b0, 1'b0, 1'b1, 16'h0, 16'h5555, 16'h0, 2'b11, 16'hAAAA, 2'd0, 6'h00);
        checkVal("fwd_11_base", {16'b0, acc_out}, 32'h5555);

        // Multiply, then wrap to zero
        doOp(3'd0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0003, 2'b00, 16'h0, 2'd0, 6'h00);
        doOp(3'd6, 1'b0, 1'b0, 1'b1, 16'h0100, 16'h0007, 16'h0020, 2'b00, 16'h0, 2'd2, 6'h15);
        checkVal("mul_3x7", {16'b0, acc_out}, 32'h0015);
        doOp(3'd7, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 2'b01, 16'h0, 2'd0, 6'h00);
        checkVal("mul_b2b_fwd", {16'b0, rs_out}, 32'h0015);
        doOp(3'd0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0100, 2'b00, 16'h0, 2'd0, 6'h00);
        doOp(3'd6, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0100, 16'h0, 2'b00, 16'h0, 2'd1, 6'h00);
        checkVal("mul_wrap_zero", {31'b0, zero_out}, 32'd1);

        // Bubble and branch wrap
        doOp(3'd7, 1'b0, 1'b0, 1'b1, 16'h0, 16'h4321, 16'h0, 2'b00, 16'h0, 2'd0, 6'h00);
        @(posedge clock); #1;
        checkVal("bubble_valid", {31'b0, out_valid}, 32'd0);
        checkVal("bubble_ctrl", {26'b0, ctrl_out}, 32'd0);
        checkVal("bubble_acc", {16'b0, acc_out}, 32'h4321);
        doOp(3'd0, 1'b0, 1'b0, 1'b0, 16'hFFFE, 16'h0, 16'h0004, 2'b00, 16'h0, 2'd0, 6'h00);
        checkVal("branch_wrap", {16'b0, jump_target}, 32'h0002);

        // Reset in the middle of a multiply
        doOp(3'd0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0009, 2'b00, 16'h0, 2'd0, 6'h00);
        @(negedge clock);
        in_valid = 1'b1; funct = 3'd6; set_out = 1'b1; reg_val = 16'h0011;
        @(posedge clock);
        @(negedge clock);
        idleInputs();
        repeat (5) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        modelReset();
        checkVal("midmul_acc", {16'b0, acc_out}, 32'd0);
        checkVal("midmul_ready", {31'b0, in_ready}, 32'd1);
        checkVal("midmul_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        sawValid = 1'b0;
        repeat (25) begin
            @(posedge clock); #1;
            if (out_valid) sawValid = 1'b1;
        end
        checkVal("midmul_no_pulse", {31'b0, sawValid}, 32'd0);
        checkVal("midmul_acc_held", {16'b0, acc_out}, 32'd0);

        // Randomised traffic
        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] rv, dm;
            rv = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            dm = W'($urandom);
            doOp(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 W'($urandom), rv, W'($urandom), 2'($urandom_range(0, 3)), dm,
                 2'($urandom_range(0, 3)), 6'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
